// File: rtl/lsu_wb_stage_if.sv
// Data-memory request/grant/response bus between the LSU (master) and data memory (slave).
interface lsu_wb_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      be;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/lsu_wb_stage.sv
// Memory-access / write-back stage: runs loads and stores over the dmem bus and
// emits one registered write-back beat per retired op.
module lsu_wb_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic [XLEN-1:0]    ex_alu_result,
   input  logic [XLEN-1:0]    ex_rs2_data,
   input  logic [XLEN-1:0]    ex_pc_plus4,
   input  logic [4:0]         ex_rd,
   input  logic               ex_reg_wen,
   input  logic [1:0]         ex_wbsel,
   input  logic               ex_mem_en,
   input  logic               ex_mem_rw,
   input  logic [2:0]         ex_funct3,
   lsu_wb_stage_if.master     dmem,
   output logic               wb_valid,
   output logic               wb_wen,
   output logic [4:0]         wb_rd,
   output logic [XLEN-1:0]    wb_data,
   output logic               misalign_exc,
   output logic [XLEN-1:0]    misalign_addr
);

   localparam int unsigned BE_W = 4;
   localparam int unsigned RD_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Operation captured at accept
   logic [XLEN-1:0] op_alu_q;
   logic [XLEN-1:0] op_pc4_q;
   logic [RD_W-1:0] op_rd_q;
   logic            op_reg_wen_q;
   logic [1:0]      op_wbsel_q;
   logic            op_store_q;
   logic [2:0]      op_funct3_q;

   // Registered outputs and their next values
   logic            ex_ready_q, ex_ready_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0] be_q, be_d;
   logic            wb_valid_q, wb_valid_d;
   logic            wb_wen_q, wb_wen_d;
   logic [RD_W-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            mis_exc_q, mis_exc_d;
   logic [XLEN-1:0] mis_addr_q, mis_addr_d;

   logic            accept;
   logic            acc_misalign;
   logic [XLEN-1:0] acc_wdata;
   logic [BE_W-1:0] acc_be;
   logic [XLEN-1:0] rd_shift;
   logic [XLEN-1:0] ld_data;
   logic            ld_done;

   // Write-back source mux; wbsel 3 aliases the ALU result
   function automatic logic [XLEN-1:0] wb_select(input logic [1:0]      sel,
                                                 input logic [XLEN-1:0] mem,
                                                 input logic [XLEN-1:0] alu,
                                                 input logic [XLEN-1:0] pc4);
      case (sel)
         2'd0:    wb_select = mem;
         2'd2:    wb_select = pc4;
         default: wb_select = alu;
      endcase
   endfunction

   assign accept = ex_valid & ex_ready_q;

   // Alignment check and store lane placement from the incoming op
   always_comb begin
      acc_misalign = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                     ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
      case (ex_funct3[1:0])
         2'b00: begin
            acc_wdata = {4{ex_rs2_data[7:0]}};
            acc_be    = BE_W'(4'b0001 << ex_alu_result[1:0]);
         end
         2'b01: begin
            acc_wdata = {2{ex_rs2_data[15:0]}};
            acc_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            acc_wdata = ex_rs2_data;
            acc_be    = 4'b1111;
         end
      endcase
   end

   // Load lane extraction; halfwords are aligned so the byte shift also serves them
   always_comb begin
      rd_shift = dmem.rdata >> {op_alu_q[1:0], 3'b000};
      case (op_funct3_q[1:0])
         2'b00:   ld_data = op_funct3_q[2] ? XLEN'(rd_shift[7:0])
                                           : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_data = op_funct3_q[2] ? XLEN'(rd_shift[15:0])
                                           : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
         default: ld_data = dmem.rdata;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      wb_valid_d = 1'b0;
      wb_wen_d   = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      mis_exc_d  = 1'b0;
      mis_addr_d = mis_addr_q;
      ld_done    = 1'b0;
      ex_ready_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!ex_mem_en) begin
                  wb_valid_d = 1'b1;
                  wb_wen_d   = ex_reg_wen & (ex_rd != 5'd0);
                  wb_rd_d    = ex_rd;
                  wb_data_d  = wb_select(ex_wbsel, '0, ex_alu_result, ex_pc_plus4);
               end else if (acc_misalign) begin
                  mis_exc_d  = 1'b1;
                  mis_addr_d = ex_alu_result;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = ex_mem_rw;
                  addr_d  = {ex_alu_result[XLEN-1:2], 2'b00};
                  wdata_d = acc_wdata;
                  be_d    = acc_be;
               end
            end
         end
         S_REQ: begin
            if (dmem.gnt) begin
               req_d = 1'b0;
               if (op_store_q) begin
                  state_d    = S_IDLE;
                  wb_valid_d = 1'b1;
                  wb_rd_d    = op_rd_q;
                  wb_data_d  = wb_select(op_wbsel_q, '0, op_alu_q, op_pc4_q);
               end else if (dmem.rvalid) begin
                  ld_done = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (dmem.rvalid) begin
               ld_done = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (ld_done) begin
         state_d    = S_IDLE;
         wb_valid_d = 1'b1;
         wb_wen_d   = op_reg_wen_q & (op_rd_q != 5'd0);
         wb_rd_d    = op_rd_q;
         wb_data_d  = wb_select(op_wbsel_q, ld_data, op_alu_q, op_pc4_q);
      end

      ex_ready_d = (state_d == S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ex_ready_q <= 1'b1;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_wen_q   <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         mis_exc_q  <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         ex_ready_q <= ex_ready_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         wb_valid_q <= wb_valid_d;
         wb_wen_q   <= wb_wen_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         mis_exc_q  <= mis_exc_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   // Capture the accepted op so later execute-side changes cannot disturb it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_alu_q     <= '0;
         op_pc4_q     <= RESET_PC4;
         op_rd_q      <= '0;
         op_reg_wen_q <= 1'b0;
         op_wbsel_q   <= '0;
         op_store_q   <= 1'b0;
         op_funct3_q  <= '0;
      end else if (accept) begin
         op_alu_q     <= ex_alu_result;
         op_pc4_q     <= ex_pc_plus4;
         op_rd_q      <= ex_rd;
         op_reg_wen_q <= ex_reg_wen;
         op_wbsel_q   <= ex_wbsel;
         op_store_q   <= ex_mem_rw;
         op_funct3_q  <= ex_funct3;
      end
   end

   assign ex_ready      = ex_ready_q;
   assign dmem.req      = req_q;
   assign dmem.we       = we_q;
   assign dmem.addr     = addr_q;
   assign dmem.wdata    = wdata_q;
   assign dmem.be       = be_q;
   assign wb_valid      = wb_valid_q;
   assign wb_wen        = wb_wen_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign misalign_exc  = mis_exc_q;
   assign misalign_addr = mis_addr_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Directed self-checking bench for lsu_wb_stage.
module tb_lsu_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_pc_plus4;
   logic [4:0]  ex_rd;
   logic        ex_reg_wen;
   logic [1:0]  ex_wbsel;
   logic        ex_mem_en;
   logic        ex_mem_rw;
   logic [2:0]  ex_funct3;
   logic        wb_valid;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign_exc;
   logic [31:0] misalign_addr;

   int n_cmp = 0;
   int n_err = 0;

   lsu_wb_stage_if #(.XLEN(32)) dmem_if ();

   lsu_wb_stage #(.XLEN(32), .RESET_PC4(32'h0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_alu_result (ex_alu_result),
      .ex_rs2_data   (ex_rs2_data),
      .ex_pc_plus4   (ex_pc_plus4),
      .ex_rd         (ex_rd),
      .ex_reg_wen    (ex_reg_wen),
      .ex_wbsel      (ex_wbsel),
      .ex_mem_en     (ex_mem_en),
      .ex_mem_rw     (ex_mem_rw),
      .ex_funct3     (ex_funct3),
      .dmem          (dmem_if.master),
      .wb_valid      (wb_valid),
      .wb_wen        (wb_wen),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .misalign_exc  (misalign_exc),
      .misalign_addr (misalign_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_mem(input logic rw, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2);
      ex_valid      = 1'b1;
      ex_mem_en     = 1'b1;
      ex_mem_rw     = rw;
      ex_funct3     = f3;
      ex_alu_result = addr;
      ex_rs2_data   = rs2;
      ex_wbsel      = 2'd0;
      ex_reg_wen    = ~rw;
      ex_rd         = 5'd10;
   endtask

   // Load with gnt after gdly cycles of REQ and rvalid rdly cycles after gnt
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp,
                           input int gdly, input int rdly);
      issue_mem(1'b0, f3, addr, 32'h0);
      step();
      ex_valid      = 1'b0;
      ex_alu_result = 32'hDEAD_BEEF;
      ex_funct3     = 3'b010;
      chk({tag, " req"}, 32'(dmem_if.req), 32'd1);
      chk({tag, " addr"}, dmem_if.addr, {addr[31:2], 2'b00});
      chk({tag, " we"}, 32'(dmem_if.we), 32'd0);
      for (int i = 0; i < gdly; i++) step();
      dmem_if.gnt = 1'b1;
      if (rdly == 0) begin
         dmem_if.rvalid = 1'b1;
         dmem_if.rdata  = rdata;
      end
      step();
      dmem_if.gnt    = 1'b0;
      dmem_if.rvalid = 1'b0;
      if (rdly > 0) begin
         for (int k = 1; k < rdly; k++) begin
            chk({tag, " wait req"}, 32'(dmem_if.req), 32'd0);
            chk({tag, " wait ready"}, 32'(ex_ready), 32'd0);
            step();
         end
         chk({tag, " pre wb_valid"}, 32'(wb_valid), 32'd0);
         dmem_if.rvalid = 1'b1;
         dmem_if.rdata  = rdata;
         step();
         dmem_if.rvalid = 1'b0;
         dmem_if.rdata  = 32'h0;
      end
      chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, " wb_data"}, wb_data, exp);
      chk({tag, " wb_wen"}, 32'(wb_wen), 32'd1);
      chk({tag, " wb_rd"}, 32'(wb_rd), 32'd10);
      chk({tag, " ready"}, 32'(ex_ready), 32'd1);
      step();
      chk({tag, " wb pulse"}, 32'(wb_valid), 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      ex_valid       = 1'b0;
      ex_alu_result  = 32'h0;
      ex_rs2_data    = 32'h0;
      ex_pc_plus4    = 32'h0;
      ex_rd          = 5'd0;
      ex_reg_wen     = 1'b0;
      ex_wbsel       = 2'd0;
      ex_mem_en      = 1'b0;
      ex_mem_rw      = 1'b0;
      ex_funct3      = 3'b000;
      dmem_if.gnt    = 1'b0;
      dmem_if.rvalid = 1'b0;
      dmem_if.rdata  = 32'h0;

      // Reset state, including a stray rvalid during reset
      dmem_if.rvalid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst wb_valid", 32'(wb_valid), 32'd0);
      chk("rst req", 32'(dmem_if.req), 32'd0);
      chk("rst be", 32'(dmem_if.be), 32'd0);
      chk("rst mis_exc", 32'(misalign_exc), 32'd0);
      chk("rst mis_addr", misalign_addr, 32'd0);
      chk("rst ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      dmem_if.rvalid = 1'b0;
      chk("idle rvalid ignored", 32'(wb_valid), 32'd0);

      // Non-memory ops back to back
      ex_valid = 1'b1; ex_mem_en = 1'b0; ex_wbsel = 2'd1; ex_rd = 5'd5;
      ex_reg_wen = 1'b1; ex_alu_result = 32'h1234; ex_pc_plus4 = 32'h99;
      step();
      chk("alu wb_valid", 32'(wb_valid), 32'd1);
      chk("alu wb_rd", 32'(wb_rd), 32'd5);
      chk("alu wb_data", wb_data, 32'h1234);
      chk("alu wb_wen", 32'(wb_wen), 32'd1);
      chk("alu ready", 32'(ex_ready), 32'd1);
      ex_rd = 5'd0; ex_alu_result = 32'h5678;
      step();
      chk("x0 wb_valid", 32'(wb_valid), 32'd1);
      chk("x0 wb_wen", 32'(wb_wen), 32'd0);
      chk("x0 wb_data", wb_data, 32'h5678);
      ex_rd = 5'd1; ex_wbsel = 2'd2; ex_pc_plus4 = 32'h104;
      step();
      chk("jal wb_data", wb_data, 32'h104);
      chk("jal wb_rd", 32'(wb_rd), 32'd1);
      ex_wbsel = 2'd3; ex_alu_result = 32'h77;
      step();
      chk("wbsel3 wb_data", wb_data, 32'h77);
      ex_valid = 1'b0;
      step();
      chk("idle wb_valid", 32'(wb_valid), 32'd0);

      // SB at 0x1003 with grant after three extra cycles
      dmem_if.gnt = 1'b1;
      step();
      chk("idle gnt ignored", 32'(dmem_if.req), 32'd0);
      dmem_if.gnt = 1'b0;
      issue_mem(1'b1, 3'b000, 32'h1003, 32'hAABB_CCDD);
      step();
      ex_valid = 1'b0; ex_alu_result = 32'h0; ex_rs2_data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         chk("sb req", 32'(dmem_if.req), 32'd1);
         chk("sb addr", dmem_if.addr, 32'h1000);
         chk("sb be", 32'(dmem_if.be), 32'h8);
         chk("sb wdata", dmem_if.wdata, 32'hDDDD_DDDD);
         chk("sb we", 32'(dmem_if.we), 32'd1);
         chk("sb ready", 32'(ex_ready), 32'd0);
         chk("sb no wb", 32'(wb_valid), 32'd0);
         if (i == 3) dmem_if.gnt = 1'b1;
         step();
      end
      dmem_if.gnt = 1'b0;
      chk("sb wb_valid", 32'(wb_valid), 32'd1);
      chk("sb wb_wen", 32'(wb_wen), 32'd0);
      chk("sb req drop", 32'(dmem_if.req), 32'd0);
      chk("sb ready", 32'(ex_ready), 32'd1);
      step();

      // Loads with sign/zero extension and a zero-latency word load
      run_load("lb", 3'b000, 32'h2003, 32'h80FF_7F01, 32'hFFFF_FF80, 1, 2);
      run_load("lbu", 3'b100, 32'h2003, 32'h80FF_7F01, 32'h0000_0080, 0, 2);
      run_load("lh", 3'b001, 32'h2002, 32'h80FF_7F01, 32'hFFFF_80FF, 0, 2);
      run_load("lhu", 3'b101, 32'h2000, 32'h80FF_7F01, 32'h0000_7F01, 0, 1);
      run_load("lw0", 3'b010, 32'h3000, 32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0);

      // Misaligned LW and SH
      issue_mem(1'b0, 3'b010, 32'h4002, 32'h0);
      step();
      ex_valid = 1'b0;
      chk("mlw exc", 32'(misalign_exc), 32'd1);
      chk("mlw addr", misalign_addr, 32'h4002);
      chk("mlw req", 32'(dmem_if.req), 32'd0);
      chk("mlw wb", 32'(wb_valid), 32'd0);
      chk("mlw ready", 32'(ex_ready), 32'd1);
      step();
      chk("mlw pulse", 32'(misalign_exc), 32'd0);
      chk("mlw hold", misalign_addr, 32'h4002);
      issue_mem(1'b1, 3'b001, 32'h4001, 32'h1122_3344);
      step();
      ex_valid = 1'b0;
      chk("msh exc", 32'(misalign_exc), 32'd1);
      chk("msh addr", misalign_addr, 32'h4001);
      chk("msh req", 32'(dmem_if.req), 32'd0);
      step();

      // Aligned SH at 0x4002 goes through normally
      issue_mem(1'b1, 3'b001, 32'h4002, 32'h1122_3344);
      step();
      ex_valid = 1'b0;
      chk("sh exc", 32'(misalign_exc), 32'd0);
      chk("sh req", 32'(dmem_if.req), 32'd1);
      chk("sh be", 32'(dmem_if.be), 32'hC);
      chk("sh wdata", dmem_if.wdata, 32'h3344_3344);
      chk("sh addr", dmem_if.addr, 32'h4000);
      dmem_if.gnt = 1'b1;
      step();
      dmem_if.gnt = 1'b0;
      chk("sh wb_valid", 32'(wb_valid), 32'd1);
      chk("sh wb_wen", 32'(wb_wen), 32'd0);
      chk("sh mis_addr hold", misalign_addr, 32'h4001);
      step();

      // Reset while in REQ drops dmem_req without a clock edge
      issue_mem(1'b0, 3'b010, 32'h5000, 32'h0);
      step();
      ex_valid = 1'b0;
      chk("rreq req", 32'(dmem_if.req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rreq async drop", 32'(dmem_if.req), 32'd0);
      chk("rreq ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset while in WAIT, then a stray rvalid
      issue_mem(1'b0, 3'b010, 32'h5000, 32'h0);
      step();
      ex_valid = 1'b0;
      dmem_if.gnt = 1'b1;
      step();
      dmem_if.gnt = 1'b0;
      chk("rwait req", 32'(dmem_if.req), 32'd0);
      chk("rwait ready", 32'(ex_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rwait ready async", 32'(ex_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      dmem_if.rvalid = 1'b1;
      dmem_if.rdata  = 32'h1357_9BDF;
      step();
      dmem_if.rvalid = 1'b0;
      chk("stray wb_valid", 32'(wb_valid), 32'd0);
      chk("stray wb_data", wb_data, 32'd0);
      chk("stray wb_rd", 32'(wb_rd), 32'd0);
      chk("stray mis_addr", misalign_addr, 32'd0);
      chk("stray req", 32'(dmem_if.req), 32'd0);
      chk("stray ready", 32'(ex_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
